// File: rtl/reg_clint.sv
// -----------------------------------------------------------------------------
// reg_clint: core-local interruptor (CLINT) on a simple register bus.
//
// Holds a 64-bit mtime counter advanced by a 16-bit prescaler, a 64-bit
// mtimecmp compare value, a software-interrupt bit (MSIP) and an enable bit.
// It produces registered timer (mtip_o) and software (msip_o) interrupts.
//
// Ports
//   clk_i    : single clock, all state changes on the rising edge
//   rst_i    : synchronous, active-low reset
//   en_i     : bus access strobe
//   we_i     : 1 = write, 0 = read (qualified by en_i)
//   addr_i   : byte address, only addr_i[4:2] selects a register
//   wdata_i  : write data, only [31:0] is used
//   rdata_o  : registered read data, upper bits always zero
//   mtip_o   : timer interrupt, registered (mtime >= mtimecmp)
//   msip_o   : software interrupt, MSIP bit 0
//
// Register map (word index addr_i[4:2])
//   0 MTIME_LO   1 MTIME_HI   2 MTIMECMP_LO   3 MTIMECMP_HI
//   4 MSIP[0]    5 PRESCALE[15:0]   6 CTRL[0]=enable   7 reserved (reads 0)
//
// Bus handshake: there is no ready/valid back-pressure. An access is offered
// when en_i=1 and always completes in that same cycle: a write lands on the
// edge that ends the cycle, and read data for the cycle's address appears on
// rdata_o after that same edge and is held until the next read.
// -----------------------------------------------------------------------------
module reg_clint #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mtip_o,
    output logic                  msip_o
);

    localparam logic [2:0] SEL_MTIME_LO    = 3'd0;
    localparam logic [2:0] SEL_MTIME_HI    = 3'd1;
    localparam logic [2:0] SEL_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] SEL_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] SEL_MSIP        = 3'd4;
    localparam logic [2:0] SEL_PRESCALE    = 3'd5;
    localparam logic [2:0] SEL_CTRL        = 3'd6;

    // Address and data bits outside the decoded range are ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0], wdata_i[DATA_WIDTH-1:32]};

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    logic [2:0]  reg_sel;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;

    assign reg_sel = addr_i[4:2];
    assign wdata   = wdata_i[31:0];
    assign wr_en   = en_i & we_i;
    assign rd_en   = en_i & ~we_i;

    logic wr_mtime_lo;
    logic wr_mtime_hi;
    logic wr_mtimecmp_lo;
    logic wr_mtimecmp_hi;
    logic wr_msip;
    logic wr_prescale;
    logic wr_ctrl;

    always_comb begin
        wr_mtime_lo    = 1'b0;
        wr_mtime_hi    = 1'b0;
        wr_mtimecmp_lo = 1'b0;
        wr_mtimecmp_hi = 1'b0;
        wr_msip        = 1'b0;
        wr_prescale    = 1'b0;
        wr_ctrl        = 1'b0;
        if (wr_en) begin
            case (reg_sel)
                SEL_MTIME_LO:    wr_mtime_lo    = 1'b1;
                SEL_MTIME_HI:    wr_mtime_hi    = 1'b1;
                SEL_MTIMECMP_LO: wr_mtimecmp_lo = 1'b1;
                SEL_MTIMECMP_HI: wr_mtimecmp_hi = 1'b1;
                SEL_MSIP:        wr_msip        = 1'b1;
                SEL_PRESCALE:    wr_prescale    = 1'b1;
                SEL_CTRL:        wr_ctrl        = 1'b1;
                default:         ; // reserved slot: writes are dropped
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Architectural state
    // ---------------------------------------------------------------------
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic        msip_q;
    logic [15:0] prescale_q;
    logic        ctrl_en_q;
    logic [15:0] presc_cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic        mtip_q;

    // ---------------------------------------------------------------------
    // Prescaler and mtime next-state
    // ---------------------------------------------------------------------
    logic        tick;
    logic [63:0] mtime_d;
    logic [15:0] presc_cnt_d;

    // One tick each time the counter reaches PRESCALE, so the tick period is
    // PRESCALE+1 enabled cycles (every cycle for PRESCALE=0).
    assign tick = ctrl_en_q && (presc_cnt_q == prescale_q);

    always_comb begin
        mtime_d = mtime_q;
        // A bus write to either half wins over a same-cycle tick; the tick
        // is dropped and the other half keeps its value.
        if (wr_mtime_lo) begin
            mtime_d[31:0] = wdata;
        end else if (wr_mtime_hi) begin
            mtime_d[63:32] = wdata;
        end else if (tick) begin
            // Full 64-bit add: the carry into the upper half lands on the
            // same edge, and all-ones wraps silently to zero.
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (wr_prescale || wr_ctrl) begin
            presc_cnt_d = 16'd0;
        end else if (ctrl_en_q) begin
            presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Read mux (combinational view of the addressed register)
    // ---------------------------------------------------------------------
    logic [31:0]           rd_val;
    logic [DATA_WIDTH-1:0] rd_ext;

    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            SEL_MTIME_LO:    rd_val = mtime_q[31:0];
            SEL_MTIME_HI:    rd_val = mtime_q[63:32];
            SEL_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            SEL_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            SEL_MSIP:        rd_val = {31'd0, msip_q};
            SEL_PRESCALE:    rd_val = {16'd0, prescale_q};
            SEL_CTRL:        rd_val = {31'd0, ctrl_en_q};
            default:         rd_val = 32'd0;
        endcase
    end

    always_comb begin
        rd_ext        = '0;
        rd_ext[31:0]  = rd_val;
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            prescale_q  <= 16'd0;
            ctrl_en_q   <= 1'b0;
            presc_cnt_q <= 16'd0;
            rdata_q     <= '0;
            mtip_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            presc_cnt_q <= presc_cnt_d;

            if (wr_mtimecmp_lo) mtimecmp_q[31:0]  <= wdata;
            if (wr_mtimecmp_hi) mtimecmp_q[63:32] <= wdata;
            if (wr_msip)        msip_q            <= wdata[0];
            if (wr_prescale)    prescale_q        <= wdata[15:0];
            if (wr_ctrl)        ctrl_en_q         <= wdata[0];

            // Read data only changes on a read; other cycles hold it.
            if (rd_en) rdata_q <= rd_ext;

            // Compare uses the current register values, so the interrupt
            // follows state with one cycle of lag and is never sticky.
            mtip_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign rdata_o = rdata_q;
    assign mtip_o  = mtip_q;
    // The MSIP register itself is the registered interrupt output; it
    // updates on the edge that writes MSIP.
    assign msip_o  = msip_q;

endmodule

// File: tb/tb_reg_clint.sv
// -----------------------------------------------------------------------------
// tb_reg_clint: directed self-checking bench for reg_clint.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_reg_clint;

    localparam int AW = 64;
    localparam int DW = 64;

    localparam logic [2:0] A_MTIME_LO    = 3'd0;
    localparam logic [2:0] A_MTIME_HI    = 3'd1;
    localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] A_MSIP        = 3'd4;
    localparam logic [2:0] A_PRESCALE    = 3'd5;
    localparam logic [2:0] A_CTRL        = 3'd6;
    localparam logic [2:0] A_RSVD        = 3'd7;

    logic          clk_i;
    logic          rst_i;
    logic          en_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          mtip_o;
    logic          msip_o;

    int n_checks;
    int n_fails;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rd_data;

    reg_clint #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .mtip_o  (mtip_o),
        .msip_o  (msip_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog: the sequence is fixed-length, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected sequence end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        en_i    = 1'b1;
        we_i    = 1'b1;
        addr_i  = AW'(a) << 2;
        wdata_i = {32'hA5A5_A5A5, d};
        step(1);
        en_i    = 1'b0;
        we_i    = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [DW-1:0] d);
        en_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = AW'(a) << 2;
        step(1);
        en_i   = 1'b0;
        d      = rdata_o;
    endtask

    // Expected value goes through the queue, then the read result is
    // compared against the popped entry.
    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [DW-1:0] got;
        exp_q.push_back(DW'(exp));
        read_reg(a, got);
        check(tag, got, exp_q.pop_front());
    endtask

    task automatic check_reset_map(input string pfx);
        read_check({pfx, "_mtime_lo"},    A_MTIME_LO,    32'h0);
        read_check({pfx, "_mtime_hi"},    A_MTIME_HI,    32'h0);
        read_check({pfx, "_mtimecmp_lo"}, A_MTIMECMP_LO, 32'hFFFF_FFFF);
        read_check({pfx, "_mtimecmp_hi"}, A_MTIMECMP_HI, 32'hFFFF_FFFF);
        read_check({pfx, "_msip"},        A_MSIP,        32'h0);
        read_check({pfx, "_prescale"},    A_PRESCALE,    32'h0);
        read_check({pfx, "_ctrl"},        A_CTRL,        32'h0);
        read_check({pfx, "_rsvd"},        A_RSVD,        32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_i    = 1'b0;
        en_i     = 1'b0;
        we_i     = 1'b0;
        addr_i   = '0;
        wdata_i  = '0;

        // Reset state
        step(3);
        rst_i = 1'b1;
        check("rst_rdata", rdata_o, 64'h0);
        check("rst_mtip", {63'd0, mtip_o}, 64'h0);
        check("rst_msip", {63'd0, msip_o}, 64'h0);
        check_reset_map("rst");

        // Write masking and the reserved slot
        write_reg(A_PRESCALE, 32'h0001_2345);
        read_check("prescale_mask", A_PRESCALE, 32'h0000_2345);
        write_reg(A_RSVD, 32'hDEAD_BEEF);
        read_check("rsvd_read_zero", A_RSVD, 32'h0);

        // Prescaled counting: PRESCALE=3 gives one tick per 4 enabled cycles
        write_reg(A_PRESCALE, 32'd3);
        write_reg(A_CTRL, 32'd1);
        step(40);
        read_reg(A_MTIME_LO, rd_data);
        check("prescaled_lo_in_range",
              {63'd0, (rd_data >= 64'd9) && (rd_data <= 64'd11)}, 64'd1);
        read_check("prescaled_hi", A_MTIME_HI, 32'h0);
        // Stopping the timer freezes mtime at 10 ticks
        write_reg(A_CTRL, 32'd0);
        read_check("hold_disabled_a", A_MTIME_LO, 32'd10);
        step(5);
        read_check("hold_disabled_b", A_MTIME_LO, 32'd10);

        // Full 64-bit wrap: all-ones plus one tick
        write_reg(A_MTIME_LO, 32'hFFFF_FFFF);
        write_reg(A_MTIME_HI, 32'hFFFF_FFFF);
        write_reg(A_PRESCALE, 32'd0);
        write_reg(A_CTRL, 32'd1);
        write_reg(A_CTRL, 32'd0);   // exactly one enabled edge -> one tick
        read_check("wrap_lo", A_MTIME_LO, 32'h0);
        read_check("wrap_hi", A_MTIME_HI, 32'h0);

        // Carry from low half into high half
        write_reg(A_MTIME_LO, 32'hFFFF_FFFF);
        write_reg(A_MTIME_HI, 32'h0);
        write_reg(A_CTRL, 32'd1);
        write_reg(A_CTRL, 32'd0);
        read_check("carry_hi", A_MTIME_HI, 32'd1);
        read_check("carry_lo", A_MTIME_LO, 32'd0);

        // Timer interrupt: mtime counts 0,1,2.. from the CTRL write edge
        write_reg(A_MTIME_LO, 32'd0);
        write_reg(A_MTIME_HI, 32'd0);
        write_reg(A_CTRL, 32'd1);          // mtime=0 after this edge
        write_reg(A_MTIMECMP_HI, 32'd0);   // mtime=1
        write_reg(A_MTIMECMP_LO, 32'd22);  // mtime=2, compare = mtime+20
        check("mtip_after_cmp_write", {63'd0, mtip_o}, 64'd0);
        step(20);
        check("mtip_before_match", {63'd0, mtip_o}, 64'd0);
        step(1);
        check("mtip_at_match", {63'd0, mtip_o}, 64'd1);
        write_reg(A_MTIMECMP_HI, 32'd1);
        check("mtip_lag_after_raise", {63'd0, mtip_o}, 64'd1);
        step(1);
        check("mtip_fall_after_raise", {63'd0, mtip_o}, 64'd0);

        // Write beats tick (timer running at PRESCALE=0)
        write_reg(A_MTIME_LO, 32'd5);
        read_check("wr_prio_lo_first", A_MTIME_LO, 32'd5);
        read_check("wr_prio_lo_next", A_MTIME_LO, 32'd6);
        read_check("wr_prio_hi_zero", A_MTIME_HI, 32'd0);
        write_reg(A_MTIME_HI, 32'd7);      // low half held at 8, tick lost
        read_check("wr_hi_lo_held", A_MTIME_LO, 32'd8);
        read_check("wr_hi_value", A_MTIME_HI, 32'd7);
        write_reg(A_CTRL, 32'd0);

        // MSIP
        write_reg(A_MSIP, 32'hFFFF_FFFF);
        check("msip_out_set", {63'd0, msip_o}, 64'd1);
        read_check("msip_read", A_MSIP, 32'd1);

        // Held read: en_i stays high on PRESCALE for four cycles
        write_reg(A_PRESCALE, 32'h0001_2345);
        en_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = AW'(A_PRESCALE) << 2;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("held_read_%0d", i), rdata_o, 64'h2345);
        end
        en_i = 1'b0;
        step(2);
        check("rdata_hold_idle", rdata_o, 64'h2345);
        write_reg(A_MSIP, 32'd0);
        check("msip_out_clear", {63'd0, msip_o}, 64'd0);
        check("rdata_hold_write", rdata_o, 64'h2345);
        write_reg(A_MSIP, 32'd1);

        // CTRL masks to bit 0
        read_check("ctrl_off", A_CTRL, 32'd0);
        write_reg(A_CTRL, 32'hFFFF_FFFF);
        read_check("ctrl_mask", A_CTRL, 32'd1);

        // Reset in the middle of a prescale count, with a write colliding
        write_reg(A_PRESCALE, 32'd3);
        write_reg(A_MTIMECMP_LO, 32'd0);
        write_reg(A_MTIMECMP_HI, 32'd0);
        step(1);
        check("mtip_cmp_zero", {63'd0, mtip_o}, 64'd1);
        step(6);
        read_check("pre_reset_prescale", A_PRESCALE, 32'd3);
        rst_i   = 1'b0;
        en_i    = 1'b1;
        we_i    = 1'b1;
        addr_i  = AW'(A_MTIME_LO) << 2;
        wdata_i = 64'h55;
        step(1);
        rst_i = 1'b1;
        en_i  = 1'b0;
        we_i  = 1'b0;
        check("rst2_rdata", rdata_o, 64'h0);
        check("rst2_mtip", {63'd0, mtip_o}, 64'h0);
        check("rst2_msip", {63'd0, msip_o}, 64'h0);
        check_reset_map("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
